// File: rtl/csa_pkg.sv
// Shared types and sizing helpers for the carry-save resolver.
// Resolver FSM encoding, default geometry, slice count and index width.
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_SLICE = 8;

    function automatic int num_slices(input int width, input int slice);
        return width / slice;
    endfunction

    // A single-slice configuration still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/csa_slice_adder.sv
// Combinational SLICE-bit adder with carry in/out; zero latency, no flow control.
module csa_slice_adder #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};

endmodule

// File: rtl/csa_resolver.sv
// Resolves a carry-save pair into one binary word, SLICE bits per clock, LSB slice first.
// Result valid NUM_SLICES edges after accept; held in DONE until out_ready, no input accepted meanwhile.
module csa_resolver
    import csa_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout
);

    localparam int NUM_SLICES = num_slices(WIDTH, SLICE);
    localparam int IDX_W      = idx_width(NUM_SLICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    if (WIDTH % SLICE != 0) begin : g_bad_slice
        $error("csa_resolver: WIDTH must be a multiple of SLICE");
    end

    state_t             state;
    logic [WIDTH-1:0]   sum_q;
    logic [WIDTH-1:0]   carry_q;
    logic               carry_reg;
    logic [IDX_W-1:0]   idx;
    logic [SLICE-1:0]   slice_sum;
    logic [SLICE-1:0]   slice_carry;
    logic [SLICE-1:0]   slice_r;
    logic               slice_c;

    assign slice_sum   = sum_q[int'(idx)*SLICE +: SLICE];
    assign slice_carry = carry_q[int'(idx)*SLICE +: SLICE];

    csa_slice_adder #(
        .SLICE (SLICE)
    ) u_slice_adder (
        .a    (slice_sum),
        .b    (slice_carry),
        .cin  (carry_reg),
        .sum  (slice_r),
        .cout (slice_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_cout   <= 1'b0;
            idx        <= '0;
            carry_reg  <= 1'b0;
            sum_q      <= '0;
            carry_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sum_q      <= in_sum;
                        carry_q    <= in_carry;
                        carry_reg  <= 1'b0;
                        idx        <= '0;
                        out_result <= '0;
                        in_ready   <= 1'b0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    out_result[int'(idx)*SLICE +: SLICE] <= slice_r;
                    carry_reg <= slice_c;
                    if (idx == LAST_IDX) begin
                        // Top slice: its carry is the word's carry out.
                        out_cout  <= slice_c;
                        idx       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_resolver.sv
// Scoreboard bench for csa_resolver: directed vectors, backpressure, reset abort, CSA-fed random stream.
module tb_csa_resolver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_sum = '0;
    logic [31:0] in_carry = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_cout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    csa_resolver #(
        .WIDTH (32),
        .SLICE (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_carry   (in_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_cout   (out_cout)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a result is consumed at the next edge when valid and ready are both high.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got 0x%0h expected none", out_result);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("result", {31'b0, out_cout, out_result}, {31'b0, e});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents an operand pair, waits for acceptance, optionally queues the expected result.
    task automatic issue(input logic [31:0] s, input logic [31:0] c, input logic [32:0] e,
                         input bit push, output int acc_cyc);
        in_sum   = s;
        in_carry = c;
        in_valid = 1'b1;
        for (int n = 0; n < 50 && !in_ready; n++) begin
            @(posedge clk);
            #1;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    logic [31:0] dir_s [3] = '{32'h0000000F, 32'h000000FF, 32'hFFFFFFFF};
    logic [31:0] dir_c [3] = '{32'h00000002, 32'h00000001, 32'h00000002};
    logic [32:0] dir_e [3] = '{{1'b0, 32'h00000011}, {1'b0, 32'h00000100}, {1'b1, 32'h00000001}};

    initial begin
        int acc;
        int prev;
        int n;
        logic [31:0] a, b, c, s, cr, sm;
        logic [32:0] full;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_result", out_result, 0);
        check("reset_out_cout", out_cout, 0);

        // Directed vectors with latency check.
        for (int i = 0; i < 3; i++) begin
            issue(dir_s[i], dir_c[i], dir_e[i], 1'b1, acc);
            in_valid = 1'b0;
            check("busy_in_ready", in_ready, 0);
            wait_valid(n);
            check("latency", n, 4);
            @(posedge clk);
            #1;
            check("idle_out_valid", out_valid, 0);
            check("idle_in_ready", in_ready, 1);
        end

        // Backpressure: result held while out_ready is low, new operand not accepted.
        out_ready = 1'b0;
        issue(32'h00001000, 32'h00000234, {1'b0, 32'h00001234}, 1'b1, acc);
        wait_valid(n);
        check("bp_latency", n, 4);
        in_sum   = 32'h12345678;
        in_carry = 32'h00000000;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_out_result", out_result, 32'h00001234);
            check("bp_out_cout", out_cout, 0);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        issue(32'h12345678, 32'h00000000, {1'b0, 32'h12345678}, 1'b1, acc);
        in_valid = 1'b0;
        wait_valid(n);
        check("bp_next_latency", n, 4);
        @(posedge clk);
        #1;

        // Reset mid-operation: abort after two BUSY edges, no residue afterwards.
        issue(32'hFFFFFFFF, 32'h00000001, '0, 1'b0, acc);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_result", out_result, 0);
        check("abort_out_cout", out_cout, 0);
        issue(32'h00000005, 32'h00000006, {1'b0, 32'h0000000B}, 1'b1, acc);
        in_valid = 1'b0;
        wait_valid(n);
        check("abort_next_latency", n, 4);
        @(posedge clk);
        #1;

        // Random CSA-fed stream with in_valid and out_ready held high.
        prev = 0;
        for (int k = 0; k < 1000; k++) begin
            a  = $urandom;
            b  = $urandom;
            c  = $urandom;
            s  = a ^ b ^ c;
            cr = ((a & b) | (a & c) | (b & c)) << 1;
            sm = a + b + c;
            full = {1'b0, s} + {1'b0, cr};
            issue(s, cr, {full[32], sm}, 1'b1, acc);
            if (k > 0) check("interval", acc - prev, 6);
            prev = acc;
        end
        in_valid = 1'b0;

        repeat (10) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
